// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared encodings, FSM state type and HAM iteration constants
package cmp_pkg;

    localparam int CMP_DATA_W = 32;
    localparam int CMP_NIB_W  = 4;
    localparam int HAM_STEPS  = CMP_DATA_W / CMP_NIB_W;
    localparam int HAM_CNT_W  = 6;
    localparam int STEP_W     = $clog2(HAM_STEPS);

    localparam logic [1:0] OP_HAM = 2'b00;
    localparam logic [1:0] OP_LUI = 2'b01;
    localparam logic [1:0] OP_SLT = 2'b10;
    localparam logic [1:0] OP_SGT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/pop4.sv
// rtl/pop4.sv - combinational popcount of one 4-bit nibble
module pop4 (
    input  logic [3:0] i_nib,
    output logic [2:0] o_cnt
);

    assign o_cnt = 3'(i_nib[0]) + 3'(i_nib[1]) + 3'(i_nib[2]) + 3'(i_nib[3]);

endmodule

// File: rtl/cmp_exec_unit.sv
// rtl/cmp_exec_unit.sv - execute-stage unit for HAM/LUI/SLT/SGT with valid/ready on both sides
module cmp_exec_unit
    import cmp_pkg::*;
#(
    parameter int DATA_W = CMP_DATA_W,
    parameter int NIB_W  = CMP_NIB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    cmp_state_t r_state;
    cmp_state_t w_state_next;

    logic [DATA_W-1:0]    r_sr;
    logic [DATA_W-1:0]    r_result;
    logic [HAM_CNT_W-1:0] r_acc;
    logic [STEP_W-1:0]    r_step;

    logic [HAM_CNT_W-1:0] w_acc_next;
    logic [2:0]           w_pop;
    logic                 w_accept;
    logic                 w_last_step;
    logic                 w_lt_ab;
    logic                 w_lt_ba;
    logic [DATA_W-1:0]    w_alu;

    // Sign bit of the 33-bit difference of sign-extended operands: exact even when a-b overflows.
    function automatic logic signed_lt(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        logic [DATA_W:0] d;
        d = {x[DATA_W-1], x} - {y[DATA_W-1], y};
        return d[DATA_W];
    endfunction

    assign w_accept    = in_valid & in_ready;
    assign w_last_step = (r_step == STEP_W'(HAM_STEPS - 1));
    assign w_lt_ab     = signed_lt(a, b);
    assign w_lt_ba     = signed_lt(b, a);
    assign w_acc_next  = r_acc + HAM_CNT_W'(w_pop);
    assign result      = r_result;

    pop4 u_pop4 (
        .i_nib (r_sr[NIB_W-1:0]),
        .o_cnt (w_pop)
    );

    always_comb begin
        w_alu = '0;
        case (op)
            OP_LUI:  w_alu = {a[DATA_W-1:DATA_W/2], {(DATA_W/2){1'b0}}};
            OP_SLT:  w_alu = DATA_W'(w_lt_ab);
            OP_SGT:  w_alu = DATA_W'(w_lt_ba);
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = (op == OP_HAM) ? ST_COUNT : ST_DONE;
                end
            end
            ST_COUNT: begin
                if (w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_next = (op == OP_HAM) ? ST_COUNT : ST_DONE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE:  in_ready = 1'b1;
            ST_COUNT: busy = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // HAM always runs the full 8 nibbles so latency is data-independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr     <= '0;
            r_acc    <= '0;
            r_step   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            if (op == OP_HAM) begin
                r_sr   <= a;
                r_acc  <= '0;
                r_step <= '0;
            end else begin
                r_result <= w_alu;
            end
        end else if (r_state == ST_COUNT) begin
            r_sr   <= r_sr >> NIB_W;
            r_acc  <= w_acc_next;
            r_step <= r_step + 1'b1;
            if (w_last_step) begin
                r_result <= {{(DATA_W-HAM_CNT_W){1'b0}}, w_acc_next};
            end
        end
    end

endmodule
